// File: rtl/pattern_fifo_if.sv
// Handshake/data bundle between the sequencer FSM (master) and pattern_fifo (slave).
interface pattern_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                  clear;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  rd_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output rd_data, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/pattern_fifo.sv
// Synchronous pattern FIFO with registered read data and occupancy counter.
// Optional sticky overflow/underflow flags under macro PATTERN_FIFO_ERR_FLAGS_EN.
module pattern_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input logic           clk,
  input logic           rst_n,
  pattern_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  empty_c, full_c, wr_acc_c, rd_acc_c;

  assign empty_c  = (count_q == '0);
  assign full_c   = (count_q == CW'(DEPTH));
  // A read on a full FIFO frees the slot the simultaneous write needs.
  assign wr_acc_c = bus.wr_en && (!full_c || bus.rd_en);
  assign rd_acc_c = bus.rd_en && !empty_c;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (bus.clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rd_data_d = '0;
    end else begin
      if (wr_acc_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc_c) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      if (wr_acc_c && !rd_acc_c)      count_d = count_q + CW'(1);
      else if (rd_acc_c && !wr_acc_c) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array carries no reset; contents are don't-care after a flush.
  always_ff @(posedge clk) begin
    if (wr_acc_c && !bus.clear) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.rd_data = rd_data_q;
  assign bus.count   = count_q;
  assign bus.empty   = empty_c;
  assign bus.full    = full_c;

`ifdef PATTERN_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (bus.wr_en && full_c && !bus.rd_en) overflow_d  = 1'b1;
      if (bus.rd_en && empty_c)              underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_pattern_fifo.sv
// Directed + randomized bench for pattern_fifo against a queue-based reference model.
module tb_pattern_fifo;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
`ifdef PATTERN_FIFO_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  pattern_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  pattern_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a plain queue plus the last value read out.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rd;
  bit            m_ovf, m_unf;
  bit            do_rd, do_wr;
  logic [DW-1:0] rd_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.clear) begin
      mq.delete();
      m_rd  = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      do_rd = bus.rd_en && (mq.size() > 0);
      do_wr = bus.wr_en && (mq.size() < DEPTH || bus.rd_en);
      if (FLAGS && bus.wr_en && !bus.rd_en && mq.size() == DEPTH) m_ovf = 1'b1;
      if (FLAGS && bus.rd_en && mq.size() == 0) m_unf = 1'b1;
      if (do_rd) begin
        m_rd = mq.pop_front();
        rd_log.push_back(m_rd);
      end
      if (do_wr) mq.push_back(bus.wr_data);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("cyc_rd_data",   32'(bus.rd_data),   32'(m_rd));
    chk("cyc_count",     32'(bus.count),     32'(mq.size()));
    chk("cyc_empty",     32'(bus.empty),     32'(mq.size() == 0));
    chk("cyc_full",      32'(bus.full),      32'(mq.size() == DEPTH));
    chk("cyc_overflow",  32'(bus.overflow),  32'(m_ovf));
    chk("cyc_underflow", 32'(bus.underflow), 32'(m_unf));
  end

  task automatic step(input bit c, input bit we, input logic [DW-1:0] wd, input bit re);
    bus.clear   = c;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  bit seen_aa;

  initial begin
    rst_n       = 1'b0;
    bus.clear   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full),  0);
    chk("rst_rd",    32'(bus.rd_data), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Flush with clear after 5 writes and one read
    for (int i = 0; i < 5; i++) step(0, 1, DW'(8'hA1 + i), 0);
    chk("five_count", 32'(bus.count), 5);
    step(0, 0, '0, 1);
    chk("first_read", 32'(bus.rd_data), 32'h A1);
    step(1, 1, 8'hEE, 1);
    chk("clr_count", 32'(bus.count), 0);
    chk("clr_empty", 32'(bus.empty), 1);
    chk("clr_full",  32'(bus.full),  0);
    chk("clr_rd",    32'(bus.rd_data), 0);

    // Asynchronous reset dropped in the middle of a write
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h12, 0);
    step(0, 0, '0, 1);
    bus.wr_en = 1'b1; bus.wr_data = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    chk("arst_full",  32'(bus.full),  0);
    chk("arst_rd",    32'(bus.rd_data), 0);
    @(negedge clk) rst_n = 1'b1;
    bus.wr_en = 1'b0;
    @(posedge clk); #1;
    chk("arst_discard", 32'(bus.count), 0);

    // Fill, then 20 read/write pairs across the pointer wrap
    for (int i = 0; i < 16; i++) step(0, 1, DW'(i + 1), 0);
    chk("fill_count", 32'(bus.count), 16);
    chk("fill_full",  32'(bus.full),  1);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, '0, 1);
      chk("order_rd", 32'(bus.rd_data), 32'(i + 1));
      step(0, 1, DW'(8'h11 + i), 0);
    end
    chk("pairs_count", 32'(bus.count), 16);

    // Write on full without read is rejected
    step(0, 1, 8'hAA, 0);
    chk("ovf_count", 32'(bus.count), 16);
    chk("ovf_flag",  32'(bus.overflow), 32'(FLAGS));

    // Simultaneous write/read on full
    step(0, 1, 8'h55, 1);
    chk("sim_full_rd",    32'(bus.rd_data), 32'h15);
    chk("sim_full_count", 32'(bus.count), 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, '0, 1);
      if (i < 15) chk("drain_rd", 32'(bus.rd_data), 32'(8'h16 + i));
    end
    chk("sixteenth_55", 32'(bus.rd_data), 32'h55);
    seen_aa = 1'b0;
    foreach (rd_log[k]) if (rd_log[k] == 8'hAA) seen_aa = 1'b1;
    chk("aa_never_read", 32'(seen_aa), 0);

    // Empty boundary
    step(0, 0, '0, 1);
    chk("unf_rd_hold", 32'(bus.rd_data), 32'h55);
    chk("unf_count",   32'(bus.count), 0);
    chk("unf_flag",    32'(bus.underflow), 32'(FLAGS));
    step(0, 1, 8'h33, 1);
    chk("emp_sim_count", 32'(bus.count), 1);
    chk("emp_sim_rd",    32'(bus.rd_data), 32'h55);
    step(0, 0, '0, 1);
    chk("emp_sim_next",  32'(bus.rd_data), 32'h33);

    // FSM cadence: sparse read pulses
    step(1, 0, '0, 0);
    chk("clr_flags", 32'({bus.overflow, bus.underflow}), 0);
    for (int i = 0; i < 3; i++) step(0, 1, DW'(8'h71 + i), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 1);
      chk("cad_rd", 32'(bus.rd_data), 32'(8'h71 + i));
      repeat (9) step(0, 0, '0, 0);
    end
    chk("cad_empty", 32'(bus.empty), 1);

    // Random traffic; the per-cycle compare carries the checking
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 55),
           DW'($urandom), ($urandom_range(0, 99) < 45));
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
